// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: hazard FSM states, priority classes and ID/EX control-field indices.
package pipe_pkg;

  typedef enum logic {
    HZ_RUN      = 1'b0,
    HZ_LU_STALL = 1'b1
  } hz_state_t;

  typedef enum logic [1:0] {
    CLS_NORMAL,
    CLS_STALL,
    CLS_FLUSH,
    CLS_FREEZE
  } hz_class_t;

  localparam int         WB_REGWRITE = 1;
  localparam int         MEM_MEMREAD = 1;
  localparam int         EXE_ALUSRC  = 0;
  localparam logic [4:0] REG_ZERO    = 5'd0;

  function automatic logic src_match(input logic use_src, input logic [4:0] src,
                                     input logic [4:0] rd);
    return use_src && (src == rd);
  endfunction

endpackage

// File: rtl/hazard_perf_cnt.sv
// Saturating event counter used for hazard performance statistics.
module hazard_perf_cnt #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// ID/EX consumer-side hazard controller: load-use stalls, branch flushes, memory-busy freezes.
// Optional performance counters are built when HAZARD_PERF_CNT_EN is defined.
module hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int LU_STALL_CYCLES = 1,
  parameter int CNT_W           = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic             ex_memread,
  input  logic [4:0]       ex_rd,
  input  logic             ex_branch_taken,
  input  logic             mem_busy,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_write,
  output logic             idex_bubble,
  output logic             stalled
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] freeze_cnt
`endif
);

  localparam logic [2:0] LU_LOAD = 3'(LU_STALL_CYCLES - 1);

  hz_state_t state, state_nxt;
  logic [2:0] cnt, cnt_nxt;
  hz_class_t  cls;
  logic       lu_hazard;

  assign lu_hazard = ex_memread && (ex_rd != REG_ZERO) &&
                     (src_match(id_use_rs1, id_rs1, ex_rd) ||
                      src_match(id_use_rs2, id_rs2, ex_rd));

  always_comb begin
    if (mem_busy)                                    cls = CLS_FREEZE;
    else if (ex_branch_taken)                        cls = CLS_FLUSH;
    else if ((state == HZ_LU_STALL) || lu_hazard)    cls = CLS_STALL;
    else                                             cls = CLS_NORMAL;
  end

  // NOTE: non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= HZ_RUN;
      cnt   <= 3'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // NOTE: defaults first so no path leaves state_nxt/cnt_nxt unassigned (no latch).
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (cls)
      CLS_FLUSH: begin
        state_nxt = HZ_RUN;
        cnt_nxt   = 3'd0;
      end
      CLS_STALL: begin
        if (state == HZ_LU_STALL) begin
          if (cnt == 3'd1) begin
            state_nxt = HZ_RUN;
            cnt_nxt   = 3'd0;
          end else begin
            cnt_nxt = cnt - 3'd1;
          end
        end else if (LU_STALL_CYCLES > 1) begin
          state_nxt = HZ_LU_STALL;
          cnt_nxt   = LU_LOAD;
        end
      end
      default: ;
    endcase
  end

  // Outputs are forced low for the whole time reset is asserted.
  always_comb begin
    pc_write    = 1'b0;
    ifid_write  = 1'b0;
    ifid_flush  = 1'b0;
    idex_write  = 1'b0;
    idex_bubble = 1'b0;
    if (rst) begin
      case (cls)
        CLS_FLUSH: begin
          pc_write    = 1'b1;
          ifid_write  = 1'b1;
          ifid_flush  = 1'b1;
          idex_write  = 1'b1;
          idex_bubble = 1'b1;
        end
        CLS_STALL: begin
          idex_write  = 1'b1;
          idex_bubble = 1'b1;
        end
        CLS_NORMAL: begin
          pc_write    = 1'b1;
          ifid_write  = 1'b1;
          idex_write  = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign stalled = rst && !pc_write;

`ifdef HAZARD_PERF_CNT_EN
  hazard_perf_cnt #(.W(CNT_W)) u_stall_cnt (
    .clk(clk), .rst(rst), .inc(cls == CLS_STALL), .count(stall_cnt)
  );
  hazard_perf_cnt #(.W(CNT_W)) u_flush_cnt (
    .clk(clk), .rst(rst), .inc(cls == CLS_FLUSH), .count(flush_cnt)
  );
  hazard_perf_cnt #(.W(CNT_W)) u_freeze_cnt (
    .clk(clk), .rst(rst), .inc(cls == CLS_FREEZE), .count(freeze_cnt)
  );
`else
  logic unused_cnt_w;
  assign unused_cnt_w = (CNT_W > 0);
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: two instances (1- and 3-cycle load-use stall) against a rule-level model.
module tb_hazard_ctrl;

  localparam int SMALL_W = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [4:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
  logic id_use_rs1 = 0, id_use_rs2 = 0, ex_memread = 0, ex_branch_taken = 0, mem_busy = 0;

  logic pw1, iw1, if1, xw1, xb1, st1;
  logic pw3, iw3, if3, xw3, xb3, st3;
  logic [5:0] o1, o3;
  assign o1 = {pw1, iw1, if1, xw1, xb1, st1};
  assign o3 = {pw3, iw3, if3, xw3, xb3, st3};

`ifdef HAZARD_PERF_CNT_EN
  logic [SMALL_W-1:0] sc1, fc1, zc1;
  logic [31:0]        sc3, fc3, zc3;
`endif

  always #5 clk = ~clk;

  hazard_ctrl #(.LU_STALL_CYCLES(1), .CNT_W(SMALL_W)) dut1 (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_memread(ex_memread),
    .ex_rd(ex_rd), .ex_branch_taken(ex_branch_taken), .mem_busy(mem_busy),
    .pc_write(pw1), .ifid_write(iw1), .ifid_flush(if1), .idex_write(xw1),
    .idex_bubble(xb1), .stalled(st1)
`ifdef HAZARD_PERF_CNT_EN
    , .stall_cnt(sc1), .flush_cnt(fc1), .freeze_cnt(zc1)
`endif
  );

  hazard_ctrl #(.LU_STALL_CYCLES(3), .CNT_W(32)) dut3 (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_memread(ex_memread),
    .ex_rd(ex_rd), .ex_branch_taken(ex_branch_taken), .mem_busy(mem_busy),
    .pc_write(pw3), .ifid_write(iw3), .ifid_flush(if3), .idex_write(xw3),
    .idex_bubble(xb3), .stalled(st3)
`ifdef HAZARD_PERF_CNT_EN
    , .stall_cnt(sc3), .flush_cnt(fc3), .freeze_cnt(zc3)
`endif
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  // rem = stall cycles still owed after the current one.
  int rem1 = 0, rem3 = 0;
  longint pc_m1[3], pc_m3[3];  // indices: 0 stall, 1 flush, 2 freeze

  function automatic logic model_haz();
    return ex_memread && (ex_rd != 0) &&
           ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
  endfunction

  // 0 normal, 1 stall, 2 flush, 3 freeze
  function automatic int cls_of(int rem);
    if (mem_busy) return 3;
    if (ex_branch_taken) return 2;
    if (rem > 0 || model_haz()) return 1;
    return 0;
  endfunction

  function automatic logic [5:0] exp_out(int rem);
    if (!rst) return 6'b000000;
    case (cls_of(rem))
      3:       return 6'b000001;
      2:       return 6'b111110;
      1:       return 6'b000111;
      default: return 6'b110100;
    endcase
  endfunction

  function automatic int next_rem(int rem, int len);
    case (cls_of(rem))
      2:       return 0;
      1:       return (rem > 0) ? rem - 1 : len - 1;
      default: return rem;
    endcase
  endfunction

  function automatic longint sat_inc(longint v, int w, logic en);
    longint top = (longint'(1) << w) - 1;
    if (en && v != top) return v + 1;
    return v;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      rem1 <= 0;
      rem3 <= 0;
      for (int k = 0; k < 3; k++) begin
        pc_m1[k] <= 0;
        pc_m3[k] <= 0;
      end
    end else begin
      rem1 <= next_rem(rem1, 1);
      rem3 <= next_rem(rem3, 3);
      for (int k = 0; k < 3; k++) begin
        pc_m1[k] <= sat_inc(pc_m1[k], SMALL_W, cls_of(rem1) == k + 1);
        pc_m3[k] <= sat_inc(pc_m3[k], 32, cls_of(rem3) == k + 1);
      end
    end
  end

  // Compare process: every falling edge, both instances against the model.
  always @(negedge clk) begin
    check("out_l1", 64'(o1), 64'(exp_out(rem1)));
    check("out_l3", 64'(o3), 64'(exp_out(rem3)));
`ifdef HAZARD_PERF_CNT_EN
    check("stall_cnt_l1",  64'(sc1), 64'(pc_m1[0]));
    check("flush_cnt_l1",  64'(fc1), 64'(pc_m1[1]));
    check("freeze_cnt_l1", 64'(zc1), 64'(pc_m1[2]));
    check("stall_cnt_l3",  64'(sc3), 64'(pc_m3[0]));
    check("flush_cnt_l3",  64'(fc3), 64'(pc_m3[1]));
    check("freeze_cnt_l3", 64'(zc3), 64'(pc_m3[2]));
`endif
  end

  // ---------------- stimulus ----------------
  task automatic set_in(input logic [4:0] rs1, input logic [4:0] rs2, input logic u1,
                        input logic u2, input logic mr, input logic [4:0] rd,
                        input logic br, input logic busy);
    id_rs1 = rs1; id_rs2 = rs2; id_use_rs1 = u1; id_use_rs2 = u2;
    ex_memread = mr; ex_rd = rd; ex_branch_taken = br; mem_busy = busy;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic hazard_in();  set_in(5, 0, 1, 0, 1, 5, 0, 0); endtask
  task automatic bubble_in();  set_in(5, 0, 1, 0, 0, 5, 0, 0); endtask

  int n1, n3;

  initial begin
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    check("reset_outputs_zero", 64'(o3), 64'h0);
    next_cycle();
    rst = 1'b1;

    // Load-use with 1 vs 3 bubbles
    hazard_in();
    n1 = 0; n3 = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      n1 += int'(st1);
      n3 += int'(st3);
      if (i == 0) begin
        check("lu_first_l1", 64'(o1), 64'h07);
        check("lu_first_l3", 64'(o3), 64'h07);
      end
      if (i == 1) check("l1_normal_after_bubble", 64'(o1), 64'h34);
      next_cycle();
      bubble_in();
    end
    check("l1_stall_len", 64'(n1), 64'd1);
    check("l3_stall_len", 64'(n3), 64'd3);

    // Register x0 and unused sources never stall
    set_in(0, 0, 1, 1, 1, 0, 0, 0);
    @(negedge clk);
    check("x0_no_stall", 64'(o1), 64'h34);
    next_cycle();
    set_in(7, 7, 0, 0, 1, 7, 0, 0);
    @(negedge clk);
    check("unused_src_no_stall", 64'(o3), 64'h34);
    next_cycle();

    // Freeze while LU_STALL holds two cycles remaining
    hazard_in();
    @(negedge clk);
    next_cycle();
    set_in(5, 0, 1, 0, 0, 5, 0, 1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("freeze_l3", 64'(o3), 64'h01);
      next_cycle();
    end
    bubble_in();
    n3 = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n3 += int'(st3);
      next_cycle();
    end
    check("post_freeze_stalls", 64'(n3), 64'd2);

    // Branch beats a fresh hazard and aborts an in-progress stall
    set_in(5, 0, 1, 0, 1, 5, 1, 0);
    @(negedge clk);
    check("flush_over_hazard", 64'(o3), 64'h3E);
    next_cycle();
    bubble_in();
    @(negedge clk);
    check("run_after_flush", 64'(o3), 64'h34);
    next_cycle();
    hazard_in();
    @(negedge clk);
    next_cycle();
    set_in(5, 0, 1, 0, 0, 5, 1, 0);
    @(negedge clk);
    check("flush_in_lu_stall", 64'(o3), 64'h3E);
    next_cycle();
    bubble_in();
    @(negedge clk);
    check("run_after_abort", 64'(o3), 64'h34);
    next_cycle();

    // Asynchronous reset during LU_STALL
    hazard_in();
    @(negedge clk);
    next_cycle();
    bubble_in();
    rst = 1'b0;
    #1;
    check("reset_async_l3", 64'(o3), 64'h0);
`ifdef HAZARD_PERF_CNT_EN
    check("reset_stall_cnt", 64'(sc3), 64'h0);
`endif
    next_cycle();
    rst = 1'b1;
    @(negedge clk);
    check("run_after_reset", 64'(o3), 64'h34);
    next_cycle();

    // Randomized traffic with small register range to provoke matches
    for (int i = 0; i < 3000; i++) begin
      set_in(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
             ($urandom_range(0, 9) == 0), ($urandom_range(0, 6) == 0));
      if ($urandom_range(0, 299) == 0) begin
        rst = 1'b0;
        #2;
        rst = 1'b1;
      end
      next_cycle();
    end

    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Consumer-side controller for the ID/EX pipeline register in the 5-stage RV32I core.
- Reads fields the ID/EX register presents to EX: MEM bits {Branch, Memread, Memwrite}, WB_address and branch resolution. Compares them against the source registers of the instruction now in ID.
- Drives write-enable, bubble and flush controls back to PC, IF/ID and ID/EX.
- Handles load-use stalls with a configurable stall length, branch-taken flushes and memory-busy freezes. An internal FSM tracks multi-cycle stalls.

Parameters:
- LU_STALL_CYCLES, 1, bubbles inserted per load-use hazard (1..7).
- CNT_W, 32, width of optional performance counters.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- id_rs1  in  5  rs1 address of the instruction in ID.
- id_rs2  in  5  rs2 address of the instruction in ID.
- id_use_rs1  in  1  ID instruction reads rs1.
- id_use_rs2  in  1  ID instruction reads rs2.
- ex_memread  in  1  Memread bit (MEM[1]) at the ID/EX output.
- ex_rd  in  5  WB_address at the ID/EX output.
- ex_branch_taken  in  1  branch/jump resolved taken in EX this cycle.
- mem_busy  in  1  data memory not ready; whole pipeline must hold.
- pc_write  out  1  PC register update enable.
- ifid_write  out  1  IF/ID update enable.
- ifid_flush  out  1  IF/ID loads a NOP.
- idex_write  out  1  ID/EX update enable.
- idex_bubble  out  1  ID/EX loads zero into EXE/MEM/WB control fields.
- stalled  out  1  high in any cycle where pc_write=0.

Behaviour:
- lu_hazard is high when all of the following hold:
  - ex_memread=1 and ex_rd != 0;
  - (id_use_rs1 and id_rs1 == ex_rd) or (id_use_rs2 and id_rs2 == ex_rd).
- Register x0 never causes a hazard.
- FSM states: RUN, LU_STALL. A 3-bit down-counter, cnt, tracks remaining stall cycles.
- Outputs are combinational from state and inputs. Only state, cnt and the counters are registered.
- Output priority, highest first:
  1. FREEZE: mem_busy=1 in any state. pc_write=0, ifid_write=0, idex_write=0, flush=0, bubble=0. State and cnt hold.
  2. FLUSH: ex_branch_taken=1. pc_write=1, ifid_write=1, ifid_flush=1, idex_write=1, idex_bubble=1. Next state RUN, cnt=0. This aborts any LU_STALL in progress, because the stalled ID instruction is squashed.
  3. STALL, taken when in LU_STALL or when lu_hazard=1 in RUN. pc_write=0, ifid_write=0, idex_write=1, idex_bubble=1.
  4. NORMAL. All write enables 1; flush and bubble 0.
- Transitions:
  - RUN with lu_hazard and LU_STALL_CYCLES>1: go to LU_STALL, cnt=LU_STALL_CYCLES-1.
  - RUN with lu_hazard and LU_STALL_CYCLES=1: stay in RUN. The bubble has moved ex_memread to 0, so the hazard clears naturally.
  - LU_STALL: cnt decrements each non-frozen cycle. When cnt==1, the next state is RUN.
- lu_hazard in RUN during a one-cycle stall is re-evaluated on the following cycle against the bubble. No double stall occurs.
- Reset (rst=0, asynchronous): state=RUN, cnt=0, counters=0. All outputs are forced 0 while rst=0. stalled=0.
- After rst rises, outputs follow the rules above starting from the first cycle.
- Latency: zero cycles from input to control output. State updates on the next rising edge.

Optional Feature:
- Macro HAZARD_PERF_CNT_EN.
- When defined, the block adds:
  - outputs stall_cnt, flush_cnt, freeze_cnt [CNT_W-1:0];
  - each counter increments once per cycle in which its priority class is active;
  - counters saturate at all-ones and reset to 0.
- When not defined, these ports and registers are absent and the rest of the behaviour is identical.

Decomposition:
- Shared package pipe_pkg holds:
  - state enum HZ_RUN / HZ_LU_STALL;
  - control bit indices WB_REGWRITE=1, MEM_MEMREAD=1, EXE_ALUSRC=0;
  - REG_ZERO=5'd0.
- One natural sub-module: hazard_perf_cnt, a saturating counter instantiated three times under HAZARD_PERF_CNT_EN.

Test Plan:
- ex_memread=1, ex_rd=5, id_rs1=5, id_use_rs1=1, LU_STALL_CYCLES=1 -> one cycle with pc_write=0, idex_bubble=1; next cycle NORMAL.
- Same stimulus with LU_STALL_CYCLES=3 -> 3 consecutive STALL cycles, then RUN; stalled high for exactly 3 cycles.
- ex_memread=1, ex_rd=0, id_rs1=0 -> no stall; id_use_rs2=0 with a matching id_rs2 -> no stall.
- LU_STALL (cnt=2) with mem_busy=1 for 4 cycles -> all enables 0 and cnt held at 2; after mem_busy drops, 2 more STALL cycles.
- ex_branch_taken=1 together with lu_hazard=1 -> ifid_flush=1, idex_bubble=1, pc_write=1; next state RUN.
- rst pulsed low during LU_STALL -> outputs 0 immediately, state RUN after release; with HAZARD_PERF_CNT_EN, stall_cnt=0.
